// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for the buffered UART transmitter: frame config,
// FIFO push port, status flags and the serial line.
interface uart_tx_fifo_if #(
    parameter int BAUD_DIV_WIDTH = 8,
    parameter int AW             = 4
);
    logic [BAUD_DIV_WIDTH-1:0] baud_div;
    logic [1:0]                data_type;
    logic [1:0]                stop_type;
    logic                      check_en;
    logic [1:0]                check_type;
    logic                      wr_en;
    logic [7:0]                wr_data;
    logic                      send_break;
    logic                      full;
    logic                      empty;
    logic [AW:0]               count;
    logic                      overflow;
    logic                      busy;
    logic                      done;
    logic                      tx;

    modport master (
        output baud_div, data_type, stop_type, check_en, check_type,
        output wr_en, wr_data, send_break,
        input  full, empty, count, overflow, busy, done, tx
    );

    modport slave (
        input  baud_div, data_type, stop_type, check_en, check_type,
        input  wr_en, wr_data, send_break,
        output full, empty, count, overflow, busy, done, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a frame serializer with
// configurable data length, parity, stop length and line break.
module uart_tx_fifo #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int SAMPLE_COUNT   = 8
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int CLK_DIV = CLK_FREQ / 10;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW      = $clog2(2 * SAMPLE_COUNT);

    localparam logic [CW-1:0] CLK_LAST   = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] BIT_LAST   = SW'(SAMPLE_COUNT - 1);
    localparam logic [SW-1:0] HALF3_LAST = SW'(3 * SAMPLE_COUNT / 2 - 1);
    localparam logic [SW-1:0] TWO_LAST   = SW'(2 * SAMPLE_COUNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [AW:0] cnt;
    logic        full, empty, overflow;
    logic        push, pop;
    logic [7:0]  rd_data;

    // A pop on the same edge frees a slot, so a push at full is still taken.
    assign push    = bus.wr_en && (!full || pop);
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            cnt      <= wr_nxt - rd_nxt;
            full     <= (wr_nxt == {~rd_nxt[AW], rd_nxt[AW-1:0]});
            empty    <= (wr_nxt == rd_nxt);
            overflow <= bus.wr_en && full && !pop;
        end
    end

    // ---------------- serializer ----------------
    state_t                    state;
    logic                      tx, busy, done, brk_hold;
    logic [7:0]                sh;
    logic [2:0]                bit_cnt, nbits_last;
    logic                      par_en, par_bit;
    logic [SW-1:0]             stop_last;
    logic [BAUD_DIV_WIDTH-1:0] baud_lat;
    logic [CW-1:0]             clk_cnt;
    logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
    logic [SW-1:0]             sub_cnt;

    logic          clk_tick, sub_tick, unit_end, shift;
    logic [SW-1:0] unit_last;
    logic [7:0]    act_data;
    logic          par_calc;
    logic [SW-1:0] stop_calc;

    assign clk_tick = (clk_cnt == CLK_LAST);
    assign sub_tick = clk_tick && (baud_cnt == baud_lat);

    // Length of the current timing unit in sub-ticks: one bit, or the whole stop/recovery period.
    always_comb begin
        unit_last = BIT_LAST;
        if (state == STOP)  unit_last = stop_last;
        if (state == BREAK) unit_last = TWO_LAST;
    end

    assign unit_end = sub_tick && (sub_cnt == unit_last) && (state != IDLE)
                      && !(state == BREAK && brk_hold);
    assign pop      = !empty && !bus.send_break
                      && ((state == IDLE) || (state == STOP && unit_end));
    assign shift    = unit_end && ((state == START)
                      || (state == DATA && bit_cnt != nbits_last));

    // Parity and stop length derived from the live config, captured at pop.
    always_comb begin
        act_data = bus.wr_data & 8'h00;
        act_data = rd_data & (8'hFF >> bus.data_type);
        par_calc = 1'b0;
        case (bus.check_type)
            2'b00:   par_calc = ~^act_data;
            2'b01:   par_calc = ^act_data;
            2'b10:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
        stop_calc = TWO_LAST;
        if (bus.stop_type == 2'b00) stop_calc = BIT_LAST;
        if (bus.stop_type == 2'b01) stop_calc = HALF3_LAST;
    end

    // Frame context: latched at pop so mid-frame config changes have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh         <= '0;
            nbits_last <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            stop_last  <= '0;
            baud_lat   <= '0;
        end else if (pop) begin
            sh         <= rd_data;
            nbits_last <= 3'd7 - {1'b0, bus.data_type};
            par_en     <= bus.check_en;
            par_bit    <= par_calc;
            stop_last  <= stop_calc;
            baud_lat   <= bus.baud_div;
        end else begin
            if (state == IDLE && bus.send_break) baud_lat <= bus.baud_div;
            if (shift) sh <= sh >> 1;
        end
    end

    // Clock/baud/sub-tick timers; held clear in IDLE and during a held break, restart per unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt  <= '0;
            baud_cnt <= '0;
            sub_cnt  <= '0;
        end else if (state == IDLE || unit_end || (state == BREAK && brk_hold)) begin
            clk_cnt  <= '0;
            baud_cnt <= '0;
            sub_cnt  <= '0;
        end else begin
            clk_cnt <= clk_tick ? '0 : clk_cnt + 1'b1;
            if (clk_tick) baud_cnt <= sub_tick ? '0 : baud_cnt + 1'b1;
            if (sub_tick) sub_cnt <= sub_cnt + 1'b1;
        end
    end

    // Frame sequencer with registered line, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            brk_hold <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send_break) begin
                        state    <= BREAK;
                        brk_hold <= 1'b1;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end else if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: if (unit_end) begin
                    state   <= DATA;
                    tx      <= sh[0];
                    bit_cnt <= '0;
                end
                DATA: if (unit_end) begin
                    if (bit_cnt == nbits_last) begin
                        state <= par_en ? PARITY : STOP;
                        tx    <= par_en ? par_bit : 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= sh[0];
                    end
                end
                PARITY: if (unit_end) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: if (unit_end) begin
                    done <= 1'b1;
                    if (bus.send_break) begin
                        state    <= BREAK;
                        brk_hold <= 1'b1;
                        tx       <= 1'b0;
                    end else if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end
                end
                BREAK: begin
                    if (brk_hold) begin
                        if (!bus.send_break) begin
                            brk_hold <= 1'b0;
                            tx       <= 1'b1;
                        end
                    end else if (unit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = cnt;
    assign bus.overflow = overflow;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.tx       = tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames, FIFO fill/overflow, break,
// mid-frame reset and randomized frames against a segment-level line model.
module tb_uart_tx_fifo;
    localparam int CLK_DIV = 10;
    localparam int SC      = 8;
    localparam int LIMIT   = 5000;

    typedef struct packed {
        logic [7:0] baud;
        logic [1:0] dt;
        logic [1:0] st;
        logic       pe;
        logic [1:0] pt;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.BAUD_DIV_WIDTH(8), .AW(4)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ(100), .BAUD_DIV_WIDTH(8), .FIFO_DEPTH(16), .SAMPLE_COUNT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input cfg_t c);
        bus.baud_div   = c.baud;
        bus.data_type  = c.dt;
        bus.stop_type  = c.st;
        bus.check_en   = c.pe;
        bus.check_type = c.pt;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (bus.tx !== 1'b0 && lat < LIMIT) begin
            step();
            lat++;
        end
        if (lat >= LIMIT) chk("start_timeout", 32'(lat), 32'(0));
    endtask

    // Line model: the frame is a list of constant-level segments with clock durations.
    // Position 0 is the first negedge with tx low for the start bit.
    task automatic check_frame(input logic [7:0] d, input cfg_t c, input int pos0,
                               input bit more, input int brk_at, input bit scramble);
        int sub, bitc, nb, ones, n, total;
        bit lv[12];
        int st[12];
        int du[12];
        bit par;
        sub   = CLK_DIV * (int'(c.baud) + 1);
        bitc  = sub * SC;
        nb    = 8 - int'(c.dt);
        lv[0] = 1'b0; st[0] = 0; du[0] = bitc;
        n = 1; total = bitc; ones = 0;
        for (int i = 0; i < nb; i++) begin
            lv[n] = d[i]; st[n] = total; du[n] = bitc;
            total += bitc; ones += int'(d[i]); n++;
        end
        if (c.pe) begin
            case (c.pt)
                2'b00:   par = (ones % 2 == 0);
                2'b01:   par = (ones % 2 == 1);
                2'b10:   par = 1'b1;
                default: par = 1'b0;
            endcase
            lv[n] = par; st[n] = total; du[n] = bitc; total += bitc; n++;
        end
        lv[n] = 1'b1; st[n] = total;
        du[n] = (c.st == 2'b00) ? bitc : (c.st == 2'b01) ? bitc * 3 / 2 : 2 * bitc;
        total += du[n]; n++;
        for (int p = pos0; p <= total; p++) begin
            if (p != pos0) step();
            if (p == 0 && scramble) begin
                bus.baud_div   = 8'($urandom_range(0, 255));
                bus.data_type  = 2'($urandom);
                bus.stop_type  = 2'($urandom);
                bus.check_en   = 1'($urandom);
                bus.check_type = 2'($urandom);
            end
            if (p == brk_at) bus.send_break = 1'b1;
            for (int s = 0; s < n; s++) begin
                if (p == st[s])              chk($sformatf("d%02h_seg%0d_first", d, s), 32'(bus.tx), 32'(lv[s]));
                if (p == st[s] + du[s] - 1)  chk($sformatf("d%02h_seg%0d_last", d, s), 32'(bus.tx), 32'(lv[s]));
            end
            if (p == total - 1) begin
                chk($sformatf("d%02h_done_early", d), 32'(bus.done), 32'(0));
                chk($sformatf("d%02h_busy_mid", d), 32'(bus.busy), 32'(1));
            end
            if (p == total) begin
                chk($sformatf("d%02h_done", d), 32'(bus.done), 32'(1));
                if (brk_at >= 0) begin
                    chk($sformatf("d%02h_brk_tx", d), 32'(bus.tx), 32'(0));
                end else if (more) begin
                    chk($sformatf("d%02h_b2b_tx", d), 32'(bus.tx), 32'(0));
                    chk($sformatf("d%02h_b2b_busy", d), 32'(bus.busy), 32'(1));
                end else begin
                    chk($sformatf("d%02h_end_tx", d), 32'(bus.tx), 32'(1));
                    chk($sformatf("d%02h_end_busy", d), 32'(bus.busy), 32'(0));
                end
            end
        end
    endtask

    initial begin
        cfg_t       c;
        int         lat;
        logic [7:0] fd[17];
        logic [7:0] x;

        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.send_break = 1'b0;
        c = '0;
        set_cfg(c);
        step(); step();
        chk("rst_tx", 32'(bus.tx), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_ovf", 32'(bus.overflow), 32'(0));
        chk("rst_empty", 32'(bus.empty), 32'(1));
        chk("rst_full", 32'(bus.full), 32'(0));
        chk("rst_count", 32'(bus.count), 32'(0));
        rst_n = 1'b1;
        step();

        // 8N1 0x55
        c = '{baud: 8'd0, dt: 2'b00, st: 2'b00, pe: 1'b0, pt: 2'b00};
        set_cfg(c);
        push(8'h55);
        chk("8n1_pre_tx", 32'(bus.tx), 32'(1));
        chk("8n1_count", 32'(bus.count), 32'(1));
        wait_start(lat);
        chk("8n1_latency", 32'(lat), 32'(1));
        check_frame(8'h55, c, 0, 1'b0, -1, 1'b0);
        step();

        // 7E2 0x41
        c = '{baud: 8'd0, dt: 2'b01, st: 2'b10, pe: 1'b1, pt: 2'b01};
        set_cfg(c);
        push(8'h41);
        wait_start(lat);
        chk("7e2_latency", 32'(lat), 32'(1));
        check_frame(8'h41, c, 0, 1'b0, -1, 1'b0);
        step();

        // 5O1.5 0x1F
        c = '{baud: 8'd0, dt: 2'b11, st: 2'b01, pe: 1'b1, pt: 2'b00};
        set_cfg(c);
        push(8'h1F);
        wait_start(lat);
        chk("5o15_latency", 32'(lat), 32'(1));
        check_frame(8'h1F, c, 0, 1'b0, -1, 1'b0);
        step();

        // FIFO fill while the line is busy, overflow, back-to-back drain
        c = '{baud: 8'd0, dt: 2'b00, st: 2'b00, pe: 1'b0, pt: 2'b00};
        set_cfg(c);
        for (int i = 0; i < 17; i++) fd[i] = 8'($urandom);
        push(fd[0]);
        step();
        for (int k = 1; k <= 17; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = (k < 17) ? fd[k] : 8'hEE;
            step();
            chk($sformatf("fill%0d_count", k), 32'(bus.count), 32'((k < 16) ? k : 16));
            chk($sformatf("fill%0d_full", k), 32'(bus.full), 32'(k >= 16));
            chk($sformatf("fill%0d_ovf", k), 32'(bus.overflow), 32'(k == 17));
        end
        bus.wr_en = 1'b0;
        step();
        chk("ovf_pulse_end", 32'(bus.overflow), 32'(0));
        chk("ovf_count_kept", 32'(bus.count), 32'(16));
        check_frame(fd[0], c, 18, 1'b1, -1, 1'b0);
        for (int i = 1; i <= 16; i++) check_frame(fd[i], c, 0, i < 16, -1, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'(1));
        step();

        // Break requested mid-frame; queued frames resume afterwards
        push(8'h55);
        bus.wr_en = 1'b1; bus.wr_data = 8'hA3;
        step();
        bus.wr_data = 8'h3C;
        step();
        bus.wr_en = 1'b0;
        check_frame(8'h55, c, 1, 1'b1, 300, 1'b0);
        for (int i = 1; i < 1000; i++) step();
        chk("brk_hold_tx", 32'(bus.tx), 32'(0));
        chk("brk_hold_busy", 32'(bus.busy), 32'(1));
        chk("brk_hold_done", 32'(bus.done), 32'(0));
        bus.send_break = 1'b0;
        for (int j = 1; j <= 161; j++) begin
            step();
            if (j == 1)   chk("brk_rec_tx_first", 32'(bus.tx), 32'(1));
            if (j == 160) chk("brk_rec_busy", 32'(bus.busy), 32'(1));
            if (j == 161) begin
                chk("brk_rec_tx_last", 32'(bus.tx), 32'(1));
                chk("brk_idle_busy", 32'(bus.busy), 32'(0));
                chk("brk_no_done", 32'(bus.done), 32'(0));
            end
        end
        wait_start(lat);
        chk("brk_resume_lat", 32'(lat), 32'(1));
        check_frame(8'hA3, c, 0, 1'b1, -1, 1'b0);
        check_frame(8'h3C, c, 0, 1'b0, -1, 1'b0);
        step();

        // Reset in the middle of DATA
        push(8'h00);
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        step();
        bus.wr_data = 8'h22;
        step();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 200; i++) step();
        chk("pre_rst_tx", 32'(bus.tx), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(bus.tx), 32'(1));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_count", 32'(bus.count), 32'(0));
        chk("midrst_empty", 32'(bus.empty), 32'(1));
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_done", 32'(bus.done), 32'(0));
        rst_n = 1'b1;
        x = 8'hC7;
        push(x);
        chk("postrst_count", 32'(bus.count), 32'(1));
        wait_start(lat);
        chk("postrst_lat", 32'(lat), 32'(1));
        check_frame(x, c, 0, 1'b0, -1, 1'b0);
        step();

        // Randomized frames; config inputs scrambled while each frame is in flight
        for (int r = 0; r < 12; r++) begin
            c.baud = 8'($urandom_range(0, 1));
            c.dt   = 2'($urandom);
            c.st   = 2'($urandom);
            c.pe   = 1'($urandom);
            c.pt   = 2'($urandom);
            x      = 8'($urandom);
            set_cfg(c);
            push(x);
            wait_start(lat);
            chk($sformatf("rnd%0d_lat", r), 32'(lat), 32'(1));
            check_frame(x, c, 0, 1'b0, -1, 1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
